// File: rtl/factor_display_seq_pkg.sv
// Shared types and constants for the factor display stage: FSM states,
// the 7-segment hex font and the fixed blank/error glyphs.
package factor_display_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShowHi,
    StShowLo,
    StGap
  } state_e;

  localparam logic [6:0] SegBlank = 7'h00;
  localparam logic [6:0] SegErr   = 7'h79;

  // Index 0 is the least significant entry: 0,1,2,...,F (gfedcba, bit0 = a).
  localparam logic [15:0][6:0] HexFont = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment (gfedcba, active high) decoder.
module hex_to_seg7
  import factor_display_seq_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HexFont[nibble_i];

endmodule

// File: rtl/factor_display_seq.sv
// Buffers one number's prime factors from the factor engine and cycles them on a
// single 7-segment digit as high nibble, low nibble, blank, with a fixed dwell per step.
module factor_display_seq
  import factor_display_seq_pkg::*;
#(
  parameter int unsigned MaxCount = 10_000_000,
  parameter int unsigned Depth    = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_factor_i,
  input  logic       in_last_i,
  input  logic       in_prime_i,
  output logic [6:0] segments_o,
  output logic       is_prime_o
);

  localparam int unsigned DwellW = $clog2(MaxCount);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CntW   = $clog2(Depth + 1);

  state_e              state_q;
  logic [CntW-1:0]     count_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [DwellW-1:0]   dwell_q;
  logic [6:0]          seg_q;
  logic                prime_q;
  logic                ovf_q;
  logic [Depth-1:0][7:0] fbuf_q;

  logic            accept;
  logic            full;
  logic            dwell_done;
  logic [PtrW-1:0] rd_ptr_nxt;
  logic [3:0]      nib_sel;
  logic [6:0]      seg_nib;

  assign in_ready_o = ena_i;
  assign accept     = in_valid_i & ena_i;
  assign full       = (count_q == CntW'(Depth));
  assign dwell_done = (dwell_q == DwellW'(MaxCount - 1));
  assign rd_ptr_nxt = (rd_ptr_q == PtrW'(count_q - CntW'(1))) ? '0 : rd_ptr_q + PtrW'(1);

  // One decoder serves every transition: the nibble that will be on display next cycle.
  always_comb begin
    nib_sel = fbuf_q[rd_ptr_nxt][7:4];
    if (accept && in_last_i) begin
      nib_sel = (state_q == StLoad) ? fbuf_q[0][7:4] : in_factor_i[7:4];
    end else if (state_q == StShowHi) begin
      nib_sel = fbuf_q[rd_ptr_q][3:0];
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nib_sel),
    .seg_o    (seg_nib)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dwell_q  <= '0;
      seg_q    <= SegBlank;
      prime_q  <= 1'b0;
      ovf_q    <= 1'b0;
      fbuf_q   <= '0;
    end else if (ena_i) begin
      if (accept && state_q != StLoad) begin
        // A new number always wins over a pending dwell expiry.
        fbuf_q[0] <= in_factor_i;
        count_q   <= CntW'(1);
        wr_ptr_q  <= PtrW'(1);
        rd_ptr_q  <= '0;
        dwell_q   <= '0;
        ovf_q     <= 1'b0;
        if (in_last_i) begin
          state_q <= StShowHi;
          seg_q   <= seg_nib;
          prime_q <= in_prime_i;
        end else begin
          state_q <= StLoad;
          seg_q   <= SegBlank;
          prime_q <= 1'b0;
        end
      end else if (accept) begin
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          fbuf_q[wr_ptr_q] <= in_factor_i;
          wr_ptr_q         <= wr_ptr_q + PtrW'(1);
          count_q          <= count_q + CntW'(1);
        end
        if (in_last_i) begin
          state_q  <= StShowHi;
          rd_ptr_q <= '0;
          dwell_q  <= '0;
          if (full || ovf_q) begin
            seg_q   <= SegErr;
            prime_q <= 1'b0;
          end else begin
            seg_q   <= seg_nib;
            prime_q <= in_prime_i;
          end
        end
      end else if (state_q == StShowHi || state_q == StShowLo || state_q == StGap) begin
        if (dwell_done) begin
          dwell_q <= '0;
          unique case (state_q)
            StShowHi: begin
              state_q <= StShowLo;
              seg_q   <= ovf_q ? SegBlank : seg_nib;
            end
            StShowLo: begin
              state_q <= StGap;
              seg_q   <= SegBlank;
            end
            default: begin
              state_q  <= StShowHi;
              rd_ptr_q <= rd_ptr_nxt;
              seg_q    <= ovf_q ? SegErr : seg_nib;
            end
          endcase
        end else begin
          dwell_q <= dwell_q + DwellW'(1);
        end
      end
    end
  end

  assign segments_o = seg_q;
  assign is_prime_o = prime_q;

endmodule

// File: tb/tb_factor_display_seq.sv
// Directed self-checking bench for factor_display_seq with a 4-cycle dwell.
module tb_factor_display_seq;

  localparam int unsigned MaxCount = 4;
  localparam int unsigned Depth    = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ena_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_factor_i;
  logic       in_last_i;
  logic       in_prime_i;
  logic [6:0] segments_o;
  logic       is_prime_o;

  int checks   = 0;
  int failures = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] exp_f [Depth];
  int         exp_n;
  logic       exp_ovf;

  always #5 clk_i = ~clk_i;

  factor_display_seq #(
    .MaxCount (MaxCount),
    .Depth    (Depth)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ena_i       (ena_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_factor_i (in_factor_i),
    .in_last_i   (in_last_i),
    .in_prime_i  (in_prime_i),
    .segments_o  (segments_o),
    .is_prime_o  (is_prime_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [7:0] f, input logic last, input logic prime);
    in_valid_i  = 1'b1;
    in_factor_i = f;
    in_last_i   = last;
    in_prime_i  = prime;
    tick();
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    in_prime_i  = 1'b0;
    in_factor_i = 8'hAA;
  endtask

  function automatic logic [6:0] exp_seg(input int step);
    int idx;
    int ph;
    idx = (step / 3) % exp_n;
    ph  = step % 3;
    if (ph == 2) return 7'h00;
    if (exp_ovf) return (ph == 0) ? 7'h79 : 7'h00;
    return (ph == 0) ? font[exp_f[idx][7:4]] : font[exp_f[idx][3:0]];
  endfunction

  task automatic watch(input string tag, input int steps);
    for (int s = 0; s < steps; s++) begin
      for (int c = 0; c < int'(MaxCount); c++) begin
        check_eq(tag, {25'd0, segments_o}, {25'd0, exp_seg(s)});
        tick();
      end
    end
  endtask

  task automatic send_twelve();
    exp_f[0] = 8'h02; exp_f[1] = 8'h02; exp_f[2] = 8'h03; exp_n = 3; exp_ovf = 1'b0;
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h02, 1'b0, 1'b0);
    beat(8'h03, 1'b1, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; ena_i = 1'b1; in_valid_i = 1'b0;
    in_factor_i = 8'h00; in_last_i = 1'b0; in_prime_i = 1'b0;
    exp_n = 1; exp_ovf = 1'b0;
    for (int i = 0; i < int'(Depth); i++) exp_f[i] = 8'h00;
    tick();
    tick();
    check_eq("rst_seg", {25'd0, segments_o}, 32'h00);
    check_eq("rst_prime", {31'd0, is_prime_o}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready_o}, 32'd1);
    rst_ni = 1'b1;
    tick();

    // 12 = 2 * 2 * 3
    send_twelve();
    check_eq("t1_prime", {31'd0, is_prime_o}, 32'd0);
    watch("t1_seg", 12);

    // 13 is prime: single beat
    exp_f[0] = 8'h0D; exp_n = 1;
    beat(8'h0D, 1'b1, 1'b1);
    check_eq("t2_prime", {31'd0, is_prime_o}, 32'd1);
    watch("t2_seg", 6);

    // nine beats overflow an 8-entry buffer
    for (int i = 0; i < 9; i++) begin
      check_eq("t3_ready", {31'd0, in_ready_o}, 32'd1);
      beat(8'h02, (i == 8), 1'b1);
    end
    exp_ovf = 1'b1;
    check_eq("t3_prime", {31'd0, is_prime_o}, 32'd0);
    watch("t3_seg", 6);

    // new number arriving exactly on a dwell expiry in SHOW_LO
    send_twelve();
    for (int i = 0; i < 7; i++) tick();
    check_eq("t4_pre_seg", {25'd0, segments_o}, 32'h5B);
    exp_f[0] = 8'hFB; exp_n = 1;
    beat(8'hFB, 1'b1, 1'b1);
    check_eq("t4_seg", {25'd0, segments_o}, 32'h71);
    check_eq("t4_prime", {31'd0, is_prime_o}, 32'd1);
    watch("t4_loop", 6);

    // reset mid-display
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_eq("rd_seg", {25'd0, segments_o}, 32'h00);
    check_eq("rd_prime", {31'd0, is_prime_o}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("rd_idle_seg", {25'd0, segments_o}, 32'h00);

    // reset mid-load discards partial factors
    beat(8'h07, 1'b0, 1'b0);
    beat(8'h0B, 1'b0, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_eq("t5_seg", {25'd0, segments_o}, 32'h00);
    check_eq("t5_prime", {31'd0, is_prime_o}, 32'd0);
    check_eq("t5_ready", {31'd0, in_ready_o}, 32'd1);
    exp_f[0] = 8'h05; exp_n = 1;
    beat(8'h05, 1'b1, 1'b0);
    watch("t5_loop", 6);

    // ena low freezes everything, including the dwell counter
    send_twelve();
    tick();
    tick();
    check_eq("t6_pre", {25'd0, segments_o}, 32'h3F);
    ena_i       = 1'b0;
    in_valid_i  = 1'b1;
    in_factor_i = 8'hFF;
    in_last_i   = 1'b1;
    in_prime_i  = 1'b1;
    check_eq("t6_ready", {31'd0, in_ready_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t6_frz_seg", {25'd0, segments_o}, 32'h3F);
      check_eq("t6_frz_prime", {31'd0, is_prime_o}, 32'd0);
      check_eq("t6_frz_ready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid_i = 1'b0; in_last_i = 1'b0; in_prime_i = 1'b0;
    ena_i = 1'b1;
    check_eq("t6_res0", {25'd0, segments_o}, 32'h3F);
    tick();
    check_eq("t6_res1", {25'd0, segments_o}, 32'h3F);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_lo", {25'd0, segments_o}, 32'h5B);
      tick();
    end
    check_eq("t6_gap", {25'd0, segments_o}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
